// File: rtl/posit_decode_pipe.sv
// Two-stage posit field decoder with an elastic valid/ready stream.
// Stage 1 takes the magnitude; stage 2 splits regime, exponent and fraction.
module posit_decode_pipe #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_posit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sign,
  output logic            out_zero,
  output logic            out_nar,
  output logic [RS:0]     out_k,
  output logic [ES-1:0]   out_exp,
  output logic [N-3:0]    out_mant
);

  localparam int MW = N - 2;
  localparam int W  = N - 3 + ES;

  logic            s1_valid_q, s1_sign_q;
  logic            s1_zero_q, s1_nar_q;
  logic [N-2:0]    s1_mag_q;
  logic            s2_valid_q, s2_sign_q;
  logic            s2_zero_q, s2_nar_q;
  logic [RS:0]     s2_k_q;
  logic [ES-1:0]   s2_exp_q;
  logic [MW-1:0]   s2_mant_q;

  logic            s1_ld, s2_ld;
  logic            sign_d, zero_d, nar_d;
  logic [N-2:0]    mag_d;

  assign s2_ld    = !s2_valid_q || out_ready;
  assign s1_ld    = !s1_valid_q || s2_ld;
  assign in_ready = s1_ld;

  // Low N-1 bits of the negation depend only on the low input bits.
  assign sign_d = in_posit[N-1];
  assign zero_d = (in_posit == '0);
  assign nar_d  = sign_d && (in_posit[N-2:0] == '0);
  assign mag_d  = sign_d ? (~in_posit[N-2:0] + 1'b1)
                         : in_posit[N-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_mag_q   <= '0;
    end else if (s1_ld) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign_d;
        s1_zero_q <= zero_d;
        s1_nar_q  <= nar_d;
        s1_mag_q  <= mag_d;
      end
    end
  end

  logic            r, run, special;
  logic [RS:0]     m, k_d;
  logic [W-1:0]    sh;
  logic [ES-1:0]   exp_d;
  logic [MW-1:0]   mant_d;

  // The run is at least 1, so the top two body bits never reach the
  // exponent: shifting the remaining bits by m-1 aligns exp then frac.
  always_comb begin
    r   = s1_mag_q[N-2];
    m   = '0;
    run = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (s1_mag_q[i] == r)) m = m + 1'b1;
      else run = 1'b0;
    end
    sh      = {s1_mag_q[N-4:0], {ES{1'b0}}} << (m - 1'b1);
    special = s1_zero_q || s1_nar_q;
    k_d     = '0;
    exp_d   = '0;
    mant_d  = '0;
    if (!special) begin
      k_d    = r ? (m - 1'b1) : ('0 - m);
      exp_d  = sh[W-1 -: ES];
      mant_d = {1'b1, sh[W-ES-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_k_q     <= '0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
    end else if (s2_ld) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q && !special;
        s2_zero_q <= s1_zero_q;
        s2_nar_q  <= s1_nar_q;
        s2_k_q    <= k_d;
        s2_exp_q  <= exp_d;
        s2_mant_q <= mant_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;
  assign out_nar   = s2_nar_q;
  assign out_k     = s2_k_q;
  assign out_exp   = s2_exp_q;
  assign out_mant  = s2_mant_q;

endmodule
